micro_boot_ctrl: RTL and testbench

Parametrised boot and run controller for the microarchitecture. It streams a program image into instruction memory, holds the core in reset for a programmable number of cycles, then releases it and counts execution cycles. It stops on a halt indication or on a cycle-budget timeout. It sits between the core's `clk`/`reset` domain and the instruction-memory write port, and replaces hand-driven reset stimulus with a repeatable load→reset→run→done sequence.

---
 rtl/micro_boot_ctrl.sv | 168 ++++++++++++++++
 tb/tb_micro_boot_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_boot_ctrl.sv
// Boot/run sequencer: streams a program into instruction memory, holds the core
// in reset for RESET_HOLD cycles, then runs it until halt or cycle-budget expiry.
module micro_boot_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 256,
    parameter int RESET_HOLD = 10,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    input  logic              cpu_halt,
    input  logic [CNT_W-1:0]  max_cycles,
    input  logic              restart,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [ADDR_W:0]   words_loaded,
    output logic              done,
    output logic              timeout,
    output logic              load_err
);

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [ADDR_W:0]   PTR_LAST  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   PTR_ZERO  = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W:0]   PTR_ONE   = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t            state_r, state_s;
    logic [ADDR_W:0]   ptr_r, ptr_s;
    logic [HOLD_W-1:0] hold_r, hold_s;
    logic [CNT_W-1:0]  count_r, count_s;
    logic              done_r, done_s;
    logic              timeout_r, timeout_s;
    logic              load_err_r, load_err_s;
    logic              handshake_s;

    // The write pointer doubles as the words-loaded count: both advance together
    // and are only ever cleared together.
    assign handshake_s  = load_valid && (state_r == ST_LOAD) && !reset;
    assign load_ready   = (state_r == ST_LOAD);
    assign imem_we      = handshake_s;
    assign imem_addr    = ptr_r[ADDR_W-1:0];
    assign imem_wdata   = load_data;
    assign cpu_reset    = (state_r != ST_RUN);
    assign cycle_count  = count_r;
    assign words_loaded = ptr_r;
    assign done         = done_r;
    assign timeout      = timeout_r;
    assign load_err     = load_err_r;

    // Next-state and next-value logic for the sequencer.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        hold_s     = hold_r;
        count_s    = count_r;
        done_s     = done_r;
        timeout_s  = timeout_r;
        load_err_s = load_err_r;
        case (state_r)
            ST_LOAD: begin
                hold_s  = HOLD_ZERO;
                count_s = CNT_ZERO;
                if (handshake_s) begin
                    ptr_s = ptr_r + PTR_ONE;
                    if (load_last) begin
                        state_s = ST_HOLD;
                    end else if (ptr_r == PTR_LAST) begin
                        state_s    = ST_ERROR;
                        load_err_s = 1'b1;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_HOLD: begin
                count_s = CNT_ZERO;
                if (hold_r == HOLD_LAST) begin
                    state_s = ST_RUN;
                    hold_s  = HOLD_ZERO;
                end else begin
                    hold_s = hold_r + HOLD_ONE;
                end
            end
            ST_RUN: begin
                // Halt takes priority over a coincident budget expiry.
                if (cpu_halt) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else if ((max_cycles != CNT_ZERO) && (count_r == (max_cycles - CNT_ONE))) begin
                    state_s   = ST_TIMEOUT;
                    timeout_s = 1'b1;
                    count_s   = max_cycles;
                end else begin
                    count_s = count_r + CNT_ONE;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                if (restart) begin
                    state_s   = ST_HOLD;
                    hold_s    = HOLD_ZERO;
                    count_s   = CNT_ZERO;
                    done_s    = 1'b0;
                    timeout_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_ERROR: begin
                if (restart) begin
                    state_s    = ST_LOAD;
                    ptr_s      = PTR_ZERO;
                    load_err_s = 1'b0;
                end else begin
                    state_s = ST_ERROR;
                end
            end
            default: begin
                state_s = ST_LOAD;
            end
        endcase
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_LOAD;
            ptr_r      <= PTR_ZERO;
            hold_r     <= HOLD_ZERO;
            count_r    <= CNT_ZERO;
            done_r     <= 1'b0;
            timeout_r  <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            hold_r     <= hold_s;
            count_r    <= count_s;
            done_r     <= done_s;
            timeout_r  <= timeout_s;
            load_err_r <= load_err_s;
        end
    end

endmodule

// File: tb/tb_micro_boot_ctrl.sv
// Randomized bench for micro_boot_ctrl, checked against a transaction-level
// model of load → hold → run → done/timeout outcomes.
module tb_micro_boot_ctrl;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int DEPTH      = 4;
    localparam int RESET_HOLD = 10;
    localparam int CNT_W      = 16;
    localparam int NO_HALT    = 100000;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_reset;
    logic              cpu_halt;
    logic [CNT_W-1:0]  max_cycles;
    logic              restart;
    logic [CNT_W-1:0]  cycle_count;
    logic [ADDR_W:0]   words_loaded;
    logic              done;
    logic              timeout;
    logic              load_err;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    logic [DATA_W-1:0] pres_q[$];

    always #5 clk = ~clk;

    micro_boot_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .RESET_HOLD(RESET_HOLD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .cpu_halt(cpu_halt), .max_cycles(max_cycles),
        .restart(restart), .cycle_count(cycle_count), .words_loaded(words_loaded),
        .done(done), .timeout(timeout), .load_err(load_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        #1;
        check_eq({tag, ".load_ready"},   64'(load_ready),   64'd1);
        check_eq({tag, ".imem_we"},      64'(imem_we),      64'd0);
        check_eq({tag, ".imem_addr"},    64'(imem_addr),    64'd0);
        check_eq({tag, ".cpu_reset"},    64'(cpu_reset),    64'd1);
        check_eq({tag, ".cycle_count"},  64'(cycle_count),  64'd0);
        check_eq({tag, ".words_loaded"}, 64'(words_loaded), 64'd0);
        check_eq({tag, ".done"},         64'(done),         64'd0);
        check_eq({tag, ".timeout"},      64'(timeout),      64'd0);
        check_eq({tag, ".load_err"},     64'(load_err),     64'd0);
    endtask

    // Reset is held with a word offered; no write may escape.
    task automatic do_reset();
        reset      = 1'b1;
        load_valid = 1'b1;
        load_data  = $urandom;
        #1;
        check_eq("rst_we", 64'(imem_we), 64'd0);
        tick();
        reset      = 1'b0;
        load_valid = 1'b0;
        check_reset_vals("rst");
    endtask

    task automatic load_words(input int n, input bit with_last, input bit gapped);
        logic [DATA_W-1:0] d;
        wr_addr_q.delete();
        wr_data_q.delete();
        pres_q.delete();
        for (int i = 0; i < n; i++) begin
            if (gapped && i > 0) begin
                load_valid = 1'b0;
                load_last  = 1'b0;
                #1;
                check_eq("idle_we", 64'(imem_we), 64'd0);
                tick();
            end
            d = $urandom;
            pres_q.push_back(d);
            load_valid = 1'b1;
            load_data  = d;
            load_last  = with_last && (i == n - 1);
            #1;
            if (imem_we) begin
                wr_addr_q.push_back(imem_addr);
                wr_data_q.push_back(imem_wdata);
            end
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Writes must be the first n_exp offered words at consecutive addresses from 0.
    task automatic check_writes(input int n_exp);
        check_eq("wr_count", 64'(wr_addr_q.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < wr_addr_q.size(); i++) begin
            check_eq("wr_addr", 64'(wr_addr_q[i]), 64'(i));
            check_eq("wr_data", 64'(wr_data_q[i]), 64'(pres_q[i]));
        end
        check_eq("words_loaded", 64'(words_loaded), 64'(n_exp));
    endtask

    // Called at the first HOLD cycle. halt_at = non-halted run cycles before the halt.
    task automatic hold_and_run(input int halt_at, input int maxc, input int reset_at);
        int  hold = 0;
        int  k    = 1;
        bit  wrote = 1'b0;
        bit  exp_to;
        int  exp_cnt;
        cpu_halt   = 1'b0;
        max_cycles = CNT_W'(maxc);
        while (cpu_reset && hold < 200) begin
            if (imem_we || load_ready) wrote = 1'b1;
            hold++;
            tick();
        end
        check_eq("hold_len", 64'(hold), 64'(RESET_HOLD));
        check_eq("hold_quiet", 64'(wrote), 64'd0);
        while (!cpu_reset && k < 3000) begin
            if (k == reset_at) begin
                reset      = 1'b1;
                load_valid = 1'b1;
                #1;
                check_eq("midrun_we", 64'(imem_we), 64'd0);
                tick();
                reset      = 1'b0;
                load_valid = 1'b0;
                check_reset_vals("midrun");
                return;
            end
            cpu_halt = (k == halt_at + 1);
            tick();
            k++;
        end
        cpu_halt = 1'b0;
        exp_to  = (maxc != 0) && (maxc <= halt_at);
        exp_cnt = exp_to ? maxc : (halt_at % (1 << CNT_W));
        check_eq("run_ended",   64'(cpu_reset),   64'd1);
        check_eq("run_len",     64'(k - 1),       64'(exp_to ? maxc : halt_at + 1));
        check_eq("done",        64'(done),        64'(!exp_to));
        check_eq("timeout",     64'(timeout),     64'(exp_to));
        check_eq("cycle_count", 64'(cycle_count), 64'(exp_cnt));
        tick();
        tick();
        check_eq("count_frozen", 64'(cycle_count), 64'(exp_cnt));
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_eq("rs_count",     64'(cycle_count), 64'd0);
        check_eq("rs_cpu_reset", 64'(cpu_reset),   64'd1);
        check_eq("rs_done",      64'(done),        64'd0);
        check_eq("rs_timeout",   64'(timeout),     64'd0);
    endtask

    initial begin
        int n;
        int maxc;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        cpu_halt   = 1'b0;
        max_cycles = '0;
        restart    = 1'b0;
        @(negedge clk);
        do_reset();

        // Basic load and run, then restart without reload.
        load_words(4, 1'b1, 1'b0);
        check_writes(4);
        check_eq("ready_drop", 64'(load_ready), 64'd0);
        hold_and_run(20, 0, 0);
        do_restart();
        hold_and_run($urandom_range(0, 30), 0, 0);
        check_eq("wl_kept", 64'(words_loaded), 64'd4);

        // Gapped load, timeout, then halt/timeout tie.
        do_reset();
        load_words(3, 1'b1, 1'b1);
        check_writes(3);
        hold_and_run(NO_HALT, 5, 0);
        do_restart();
        hold_and_run(4, 5, 0);

        // Overflow without last, recovery, reload and mid-run reset.
        do_reset();
        load_words(DEPTH + 1, 1'b0, 1'b0);
        check_writes(DEPTH);
        check_eq("ovf_err",   64'(load_err),   64'd1);
        check_eq("ovf_ready", 64'(load_ready), 64'd0);
        check_eq("ovf_cpu",   64'(cpu_reset),  64'd1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_eq("err_rs_wl",    64'(words_loaded), 64'd0);
        check_eq("err_rs_err",   64'(load_err),     64'd0);
        check_eq("err_rs_ready", 64'(load_ready),   64'd1);
        load_words(2, 1'b1, 1'b0);
        check_writes(2);
        hold_and_run(NO_HALT, 0, 7);

        // Random rounds.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            n = $urandom_range(1, DEPTH);
            load_words(n, 1'b1, 1'($urandom_range(0, 1)));
            check_writes(n);
            maxc = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
            hold_and_run($urandom_range(0, 40), maxc, 0);
            do_restart();
            maxc = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
            hold_and_run($urandom_range(0, 40), maxc, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
